// File: rtl/contador_vga.sv
// VGA scan-position generator: pixel/line counters, pixel-tick divider, frame-aligned start/stop and frame count.
// Optional `VGA_DIV_RELOJ_EN derives a half-rate pixel tick from clk; undefined, every clk is a pixel tick.
module contador_vga #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       iniciar,
    output logic [9:0] pixel_num,
    output logic [9:0] linea_num,
    output logic       pix_tick,
    output logic       fin_linea,
    output logic       fin_cuadro,
    output logic       activo,
    output logic       corriendo,
    output logic [7:0] num_cuadros
);

    localparam logic [1:0] INACTIVO   = 2'd0;
    localparam logic [1:0] CORRIENDO  = 2'd1;
    localparam logic [1:0] DETENIENDO = 2'd2;

    localparam logic [9:0] H_ULTIMO = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ULTIMO = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE = 10'(H_ACTIVE);
    localparam logic [9:0] V_VISIBLE = 10'(V_ACTIVE);

    logic [1:0] estado_q,  estado_d;
    logic [9:0] pixel_q,   pixel_d;
    logic [9:0] linea_q,   linea_d;
    logic       activo_q,  activo_d;
    logic [7:0] cuadros_q, cuadros_d;
    logic       en_marcha;

`ifdef VGA_DIV_RELOJ_EN
    logic fase_q, fase_d;

    always_comb begin
        fase_d = ~fase_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fase_q <= 1'b0;
        end else begin
            fase_q <= fase_d;
        end
    end

    assign pix_tick = fase_q;
`else
    assign pix_tick = 1'b1;
`endif

    assign en_marcha = (estado_q != INACTIVO);

    always_comb begin
        fin_linea  = pix_tick && en_marcha && (pixel_q == H_ULTIMO);
        fin_cuadro = fin_linea && (linea_q == V_ULTIMO);

        estado_d  = estado_q;
        pixel_d   = pixel_q;
        linea_d   = linea_q;
        activo_d  = activo_q;
        cuadros_d = cuadros_q;

        if (pix_tick) begin
            case (estado_q)
                INACTIVO: begin
                    if (iniciar) estado_d = CORRIENDO;
                end
                CORRIENDO: begin
                    // A stop request only arms DETENIENDO; the frame in progress (or the next
                    // one, if this tick ends a frame) is always scanned to completion.
                    if (!iniciar) estado_d = DETENIENDO;
                end
                DETENIENDO: begin
                    if (iniciar) begin
                        estado_d = CORRIENDO;
                    end else if (fin_cuadro) begin
                        estado_d = INACTIVO;
                    end
                end
                default: estado_d = INACTIVO;
            endcase

            if (en_marcha) begin
                if (fin_linea) begin
                    pixel_d = 10'd0;
                    linea_d = fin_cuadro ? 10'd0 : linea_q + 10'd1;
                end else begin
                    pixel_d = pixel_q + 10'd1;
                end
            end else begin
                pixel_d = 10'd0;
                linea_d = 10'd0;
            end

            if (fin_cuadro) cuadros_d = cuadros_q + 8'd1;

            // Built from the next position so the flag lines up with the counters it describes.
            activo_d = (pixel_d < H_VISIBLE) && (linea_d < V_VISIBLE) && (estado_d != INACTIVO);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            estado_q  <= INACTIVO;
            pixel_q   <= 10'd0;
            linea_q   <= 10'd0;
            activo_q  <= 1'b0;
            cuadros_q <= 8'd0;
        end else begin
            estado_q  <= estado_d;
            pixel_q   <= pixel_d;
            linea_q   <= linea_d;
            activo_q  <= activo_d;
            cuadros_q <= cuadros_d;
        end
    end

    assign pixel_num   = pixel_q;
    assign linea_num   = linea_q;
    assign activo      = activo_q;
    assign corriendo   = (estado_q == CORRIENDO) || (estado_q == DETENIENDO);
    assign num_cuadros = cuadros_q;

endmodule
